ibuffer_warp_queue: RTL and testbench

- Next-generation instruction buffer between decode and issue. It holds a separate FIFO per warp instead of one FIFO per issue slot, so a stalled warp no longer blocks other warps that share its slot.
- Each issue slot arbitrates round-robin among the non-empty warps it owns.
- Adds per-warp flush, per-warp occupancy and full reporting, which fetch uses for warp scheduling.

---
 rtl/ibuffer_warp_queue.sv | 214 +++++++++++++++++++++
 tb/tb_ibuffer_warp_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer_warp_queue.sv
// ibuffer_warp_queue
//   Instruction buffer between decode and issue. Each warp owns its own FIFO,
//   so a warp that cannot issue never blocks other warps mapped to the same
//   issue slot. Warp w belongs to slot (w % ISSUE_WIDTH) at local index
//   (w / ISSUE_WIDTH). Each slot grants round-robin among its non-empty warps
//   and holds a grant stable while the consumer stalls.
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   in_valid     decoded instruction valid
//   in_wid       warp id of the incoming instruction
//   in_data      instruction payload
//   in_ready     FIFO of in_wid can accept (independent of in_valid)
//   out_valid    per-slot valid
//   out_wid      per-slot granted warp id, slot s at [s*WID_W +: WID_W]
//   out_data     per-slot head payload, slot s at [s*DATAW +: DATAW]
//   out_ready    per-slot issue accept
//   flush_valid  discard every entry of flush_wid
//   flush_wid    warp to flush
//   warp_full    per-warp FIFO holds DEPTH entries
//   warp_count   per-warp occupancy, warp w at [w*CNT_W +: CNT_W]
//   empty        all FIFOs empty

module ibuffer_warp_queue #(
    parameter int NUM_WARPS   = 8,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 4,
    parameter int DATAW       = 128,
    localparam int WID_W      = $clog2(NUM_WARPS),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WID_W-1:0]             in_wid,
    input  logic [DATAW-1:0]             in_data,
    output logic                         in_ready,
    output logic [ISSUE_WIDTH-1:0]       out_valid,
    output logic [ISSUE_WIDTH*WID_W-1:0] out_wid,
    output logic [ISSUE_WIDTH*DATAW-1:0] out_data,
    input  logic [ISSUE_WIDTH-1:0]       out_ready,
    input  logic                         flush_valid,
    input  logic [WID_W-1:0]             flush_wid,
    output logic [NUM_WARPS-1:0]         warp_full,
    output logic [NUM_WARPS*CNT_W-1:0]   warp_count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WPS   = NUM_WARPS / ISSUE_WIDTH;
    localparam int LID_W = (WPS > 1) ? $clog2(WPS) : 1;

    // Per-warp FIFO state
    logic [DATAW-1:0] mem    [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_WARPS];
    logic [PTR_W-1:0] wr_ptr [NUM_WARPS];
    logic [CNT_W-1:0] cnt    [NUM_WARPS];

    // Per-slot arbitration state
    logic [LID_W-1:0]       rr    [ISSUE_WIDTH];
    logic [LID_W-1:0]       gnt_q [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] lock;

    logic [LID_W-1:0]       gnt   [ISSUE_WIDTH];
    logic [WID_W-1:0]       gwid  [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] any_ne;
    logic [ISSUE_WIDTH-1:0] flush_hit;
    logic [ISSUE_WIDTH-1:0] valid;
    logic [ISSUE_WIDTH-1:0] fire;

    logic [NUM_WARPS-1:0]   nonempty;
    logic [NUM_WARPS-1:0]   full;
    logic [NUM_WARPS-1:0]   pop;
    logic [NUM_WARPS-1:0]   push_w;
    logic                   push;
    logic                   flush_in;

    always_comb begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            nonempty[w] = (cnt[w] != '0);
            full[w]     = (cnt[w] == CNT_W'(DEPTH));
        end
    end

    // Round-robin search: walk candidates from farthest (rr+WPS) to nearest
    // (rr+1) so the last hit written is the first non-empty warp after rr.
    always_comb begin : grant_search
        int unsigned      l;
        logic [LID_W-1:0] srch;
        logic [WID_W-1:0] w;
        l    = 0;
        srch = '0;
        w    = '0;
        for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
            any_ne[s] = 1'b0;
            srch      = rr[s];
            for (int unsigned k = WPS; k > 0; k--) begin
                l = (32'(rr[s]) + k) % WPS;
                w = WID_W'(l * ISSUE_WIDTH + s);
                if (nonempty[w]) begin
                    any_ne[s] = 1'b1;
                    srch      = LID_W'(l);
                end
            end
            gnt[s]       = lock[s] ? gnt_q[s] : srch;
            gwid[s]      = WID_W'(32'(gnt[s]) * ISSUE_WIDTH + s);
            // A flush of the granted warp hides the slot for that cycle.
            flush_hit[s] = flush_valid && any_ne[s] && (flush_wid == gwid[s]);
            valid[s]     = any_ne[s] && !flush_hit[s];
            fire[s]      = valid[s] && out_ready[s];
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
            if (fire[s]) begin
                pop[gwid[s]] = 1'b1;
            end
        end
    end

    // A push landing on a flushed warp is accepted and dropped.
    assign flush_in = flush_valid && (flush_wid == in_wid);
    assign in_ready = !full[in_wid] || pop[in_wid] || flush_in;
    assign push     = in_valid && in_ready;

    always_comb begin
        push_w = '0;
        if (push) begin
            push_w[in_wid] = 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !flush_in) begin
            mem[in_wid][wr_ptr[in_wid]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
                cnt[w]    <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                if (flush_valid && (flush_wid == WID_W'(w))) begin
                    rd_ptr[w] <= '0;
                    wr_ptr[w] <= '0;
                    cnt[w]    <= '0;
                end else begin
                    if (push_w[w]) begin
                        wr_ptr[w] <= wr_ptr[w] + 1'b1;
                    end
                    if (pop[w]) begin
                        rd_ptr[w] <= rd_ptr[w] + 1'b1;
                    end
                    if (push_w[w] && !pop[w]) begin
                        cnt[w] <= cnt[w] + 1'b1;
                    end else if (!push_w[w] && pop[w]) begin
                        cnt[w] <= cnt[w] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock <= '0;
            for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
                rr[s]    <= '0;
                gnt_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
                if (flush_hit[s]) begin
                    lock[s] <= 1'b0;
                end else if (fire[s]) begin
                    lock[s] <= 1'b0;
                    rr[s]   <= gnt[s];
                end else if (valid[s]) begin
                    lock[s]  <= 1'b1;
                    gnt_q[s] <= gnt[s];
                end
            end
        end
    end

    always_comb begin
        out_valid = valid;
        out_wid   = '0;
        out_data  = '0;
        for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
            out_wid[s*WID_W +: WID_W]  = gwid[s];
            out_data[s*DATAW +: DATAW] = mem[gwid[s]][rd_ptr[gwid[s]]];
        end
    end

    always_comb begin
        warp_count = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            warp_count[w*CNT_W +: CNT_W] = cnt[w];
        end
    end

    assign warp_full = full;
    assign empty     = ~|nonempty;

endmodule

// File: tb/tb_ibuffer_warp_queue.sv
// tb_ibuffer_warp_queue
//   Bench for ibuffer_warp_queue with 4 warps, 2 slots, depth 4. The reference
//   keeps one queue per warp plus per-slot round-robin/lock bookkeeping and
//   predicts every output each cycle; directed sequences add explicit checks.

module tb_ibuffer_warp_queue;

    localparam int NW  = 4;
    localparam int IW  = 2;
    localparam int D   = 4;
    localparam int DW  = 32;
    localparam int WW  = 2;
    localparam int CW  = 3;
    localparam int WPS = NW / IW;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [WW-1:0]    in_wid = '0;
    logic [DW-1:0]    in_data = '0;
    logic             in_ready;
    logic [IW-1:0]    out_valid;
    logic [IW*WW-1:0] out_wid;
    logic [IW*DW-1:0] out_data;
    logic [IW-1:0]    out_ready = '0;
    logic             flush_valid = 1'b0;
    logic [WW-1:0]    flush_wid = '0;
    logic [NW-1:0]    warp_full;
    logic [NW*CW-1:0] warp_count;
    logic             empty;

    ibuffer_warp_queue #(
        .NUM_WARPS  (NW),
        .ISSUE_WIDTH(IW),
        .DEPTH      (D),
        .DATAW      (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_wid     (in_wid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_wid    (out_wid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush_valid(flush_valid),
        .flush_wid  (flush_wid),
        .warp_full  (warp_full),
        .warp_count (warp_count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] q [NW][$];
    int            m_rr   [IW];
    bit            m_lock [IW];
    int            m_gnt  [IW];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Granted warp of a slot, or -1 when the slot owns no queued entry.
    function automatic int model_grant(input int s);
        if (m_lock[s]) return m_gnt[s];
        for (int k = 1; k <= WPS; k++) begin
            int w;
            w = ((m_rr[s] + k) % WPS) * IW + s;
            if (q[w].size() != 0) return w;
        end
        return -1;
    endfunction

    function automatic bit model_visible(input int g);
        return (g >= 0) && !(flush_valid && (int'(flush_wid) == g));
    endfunction

    function automatic bit model_in_ready();
        int w;
        w = int'(in_wid);
        if (q[w].size() < D) return 1'b1;
        if (flush_valid && flush_wid == in_wid) return 1'b1;
        for (int s = 0; s < IW; s++) begin
            int g;
            g = model_grant(s);
            if (model_visible(g) && out_ready[s] && g == w) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_outputs();
        bit all_empty;
        all_empty = 1'b1;
        for (int s = 0; s < IW; s++) begin
            int g;
            bit v;
            g = model_grant(s);
            v = model_visible(g);
            chk($sformatf("out_valid[%0d]", s), 64'(out_valid[s]), 64'(v));
            if (v) begin
                chk($sformatf("out_wid[%0d]", s), 64'(out_wid[s*WW +: WW]), 64'(g));
                chk($sformatf("out_data[%0d]", s), 64'(out_data[s*DW +: DW]), 64'(q[g][0]));
            end
        end
        for (int w = 0; w < NW; w++) begin
            chk($sformatf("warp_count[%0d]", w), 64'(warp_count[w*CW +: CW]), 64'(q[w].size()));
            chk($sformatf("warp_full[%0d]", w), 64'(warp_full[w]), 64'(q[w].size() == D));
            if (q[w].size() != 0) all_empty = 1'b0;
        end
        chk("empty", 64'(empty), 64'(all_empty));
        chk("in_ready", 64'(in_ready), 64'(model_in_ready()));
    endtask

    task automatic model_step();
        int g [IW];
        bit v [IW];
        bit rdy;
        rdy = model_in_ready();
        for (int s = 0; s < IW; s++) begin
            g[s] = model_grant(s);
            v[s] = model_visible(g[s]);
        end
        for (int s = 0; s < IW; s++) begin
            if (v[s] && out_ready[s]) begin
                void'(q[g[s]].pop_front());
                m_rr[s]   = g[s] / IW;
                m_lock[s] = 1'b0;
            end else if (v[s]) begin
                m_lock[s] = 1'b1;
                m_gnt[s]  = g[s];
            end else if (g[s] >= 0) begin
                m_lock[s] = 1'b0;
            end
        end
        if (in_valid && rdy && !(flush_valid && flush_wid == in_wid))
            q[in_wid].push_back(in_data);
        if (flush_valid)
            q[flush_wid].delete();
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) q[w].delete();
        for (int s = 0; s < IW; s++) begin
            m_rr[s]   = 0;
            m_lock[s] = 1'b0;
            m_gnt[s]  = 0;
        end
    endtask

    task automatic drive(input bit iv, input int wid, input logic [DW-1:0] d,
                         input logic [IW-1:0] ordy, input bit fv, input int fw);
        in_valid    = iv;
        in_wid      = WW'(wid);
        in_data     = d;
        out_ready   = ordy;
        flush_valid = fv;
        flush_wid   = WW'(fw);
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    typedef struct {
        bit            iv;
        int            wid;
        logic [DW-1:0] data;
        logic [IW-1:0] ordy;
        logic [IW-1:0] e_valid;
        int            e_wid0;
        logic [DW-1:0] e_data0;
        int            e_cnt2;
        bit            e_empty;
    } vec_t;

    vec_t tbl [3];
    int   got [$];
    int   exp_order [6];
    logic [DW-1:0] held;

    initial begin
        tbl[0] = '{1'b1, 2, 32'hA1, 2'b01, 2'b00, 0, 32'h0,  0, 1'b1};
        tbl[1] = '{1'b0, 0, 32'h0,  2'b01, 2'b01, 2, 32'hA1, 1, 1'b0};
        tbl[2] = '{1'b0, 0, 32'h0,  2'b01, 2'b00, 0, 32'h0,  0, 1'b1};
        exp_order = '{0, 2, 0, 2, 0, 2};
        model_reset();

        // Reset state
        #1 reset = 1'b1;
        #1;
        check_outputs();
        chk("reset empty", 64'(empty), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single push on wid 2 flows through slot 0
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i].iv, tbl[i].wid, tbl[i].data, tbl[i].ordy, 1'b0, 0);
            @(negedge clk);
            chk($sformatf("t1 out_valid step%0d", i), 64'(out_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_valid[0]) begin
                chk($sformatf("t1 out_wid0 step%0d", i), 64'(out_wid[WW-1:0]), 64'(tbl[i].e_wid0));
                chk($sformatf("t1 out_data0 step%0d", i), 64'(out_data[DW-1:0]), 64'(tbl[i].e_data0));
            end
            chk($sformatf("t1 count2 step%0d", i), 64'(warp_count[2*CW +: CW]), 64'(tbl[i].e_cnt2));
            chk($sformatf("t1 empty step%0d", i), 64'(empty), 64'(tbl[i].e_empty));
            check_outputs();
            at_pos();
        end

        // Fill wid 1, stall a fifth push, then push+pop on the full FIFO
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1, 32'h100 + DW'(i), 2'b00, 1'b0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1, 32'h104, 2'b00, 1'b0, 0);
            @(negedge clk);
            chk("t2 full1", 64'(warp_full[1]), 64'd1);
            chk("t2 in_ready wid1 stalled", 64'(in_ready), 64'd0);
            check_outputs();
            at_pos();
        end
        drive(1'b0, 3, 32'h0, 2'b00, 1'b0, 0);
        @(negedge clk);
        chk("t2 in_ready wid3", 64'(in_ready), 64'd1);
        check_outputs();
        at_pos();
        drive(1'b1, 1, 32'h104, 2'b10, 1'b0, 0);
        @(negedge clk);
        chk("t2 in_ready push+pop", 64'(in_ready), 64'd1);
        chk("t2 head data", 64'(out_data[DW +: DW]), 64'h100);
        check_outputs();
        at_pos();
        drive(1'b0, 0, 32'h0, 2'b00, 1'b0, 0);
        @(negedge clk);
        chk("t2 count1 kept", 64'(warp_count[1*CW +: CW]), 64'd4);
        check_outputs();
        at_pos();
        drive(1'b0, 0, 32'h0, 2'b11, 1'b0, 0);
        repeat (6) step();

        // Round-robin between wid 0 and wid 2
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 2) * 2, 32'h200 + DW'(i), 2'b00, 1'b0, 0);
            step();
        end
        drive(1'b0, 0, 32'h0, 2'b01, 1'b0, 0);
        for (int c = 0; c < 12 && got.size() < 6; c++) begin
            @(negedge clk);
            if (out_valid[0]) got.push_back(int'(out_wid[WW-1:0]));
            check_outputs();
            at_pos();
        end
        chk("t3 issue count", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size() && i < 6; i++)
            chk($sformatf("t3 order[%0d]", i), 64'(got[i]), 64'(exp_order[i]));

        // Lock holds wid 0 while wid 2 arrives
        drive(1'b1, 0, 32'h300, 2'b00, 1'b0, 0);
        step();
        held = 32'h300;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) drive(1'b1, 2, 32'h301, 2'b00, 1'b0, 0);
            else        drive(1'b0, 0, 32'h0, 2'b00, 1'b0, 0);
            @(negedge clk);
            chk($sformatf("t4 valid c%0d", c), 64'(out_valid[0]), 64'd1);
            chk($sformatf("t4 wid c%0d", c), 64'(out_wid[WW-1:0]), 64'd0);
            chk($sformatf("t4 data c%0d", c), 64'(out_data[DW-1:0]), 64'(held));
            check_outputs();
            at_pos();
        end
        drive(1'b0, 0, 32'h0, 2'b01, 1'b0, 0);
        step();
        @(negedge clk);
        chk("t4 next wid", 64'(out_wid[WW-1:0]), 64'd2);
        chk("t4 next data", 64'(out_data[DW-1:0]), 64'h301);
        check_outputs();
        at_pos();
        drive(1'b0, 0, 32'h0, 2'b00, 1'b0, 0);
        step();

        // Flush of granted wid 3 with a concurrent push
        drive(1'b1, 3, 32'h400, 2'b00, 1'b0, 0);
        step();
        drive(1'b1, 3, 32'h401, 2'b00, 1'b0, 0);
        step();
        drive(1'b1, 3, 32'hDEAD, 2'b00, 1'b1, 3);
        @(negedge clk);
        chk("t5 valid1 in flush", 64'(out_valid[1]), 64'd0);
        chk("t5 in_ready in flush", 64'(in_ready), 64'd1);
        check_outputs();
        at_pos();
        drive(1'b0, 0, 32'h0, 2'b11, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t5 count3 c%0d", c), 64'(warp_count[3*CW +: CW]), 64'd0);
            chk($sformatf("t5 valid1 c%0d", c), 64'(out_valid[1]), 64'd0);
            check_outputs();
            at_pos();
        end

        // Asynchronous reset while both slots are locked
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 32'h500 + DW'(i), 2'b00, 1'b0, 0);
            step();
        end
        drive(1'b0, 0, 32'h0, 2'b00, 1'b0, 0);
        step();
        #1 reset = 1'b1;
        #1;
        chk("t6 out_valid", 64'(out_valid), 64'd0);
        chk("t6 warp_count", 64'(warp_count), 64'd0);
        chk("t6 warp_full", 64'(warp_full), 64'd0);
        chk("t6 empty", 64'(empty), 64'd1);
        chk("t6 in_ready", 64'(in_ready), 64'd1);
        model_reset();
        check_outputs();
        @(posedge clk);
        #2 reset = 1'b0;
        drive(1'b1, 0, 32'h600, 2'b00, 1'b0, 0);
        step();
        drive(1'b0, 0, 32'h0, 2'b00, 1'b0, 0);
        @(negedge clk);
        chk("t6 post valid0", 64'(out_valid[0]), 64'd1);
        chk("t6 post wid0", 64'(out_wid[WW-1:0]), 64'd0);
        chk("t6 post data0", 64'(out_data[DW-1:0]), 64'h600);
        check_outputs();
        at_pos();
        drive(1'b0, 0, 32'h0, 2'b11, 1'b0, 0);
        repeat (2) step();

        // Randomised traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 3) != 0, int'($urandom % NW), DW'($urandom),
                  IW'($urandom), ($urandom % 10) == 0, int'($urandom % NW));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
